// File: rtl/dmem_bridge.sv
// dmem_bridge: sits behind the single-cycle MIPS datapath. Loads/stores to the
// MMIO window are answered locally with no wait; everything else goes out on a
// req/ack bus while the datapath is stalled. Owns LED, CYCLE and a sticky
// bus-timeout flag.
module dmem_bridge #(
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [7:0]  led,
  output logic        bus_err
);

  typedef enum logic [1:0] { IDLE, REQ, DONE } state_t;

  // Counter value seen in the last permitted bus_req cycle.
  localparam logic [7:0]  TO_LAST      = 8'(TIMEOUT - 1);
  localparam logic [29:0] BASE_WORD    = MMIO_BASE[31:2];
  localparam logic [29:0] REG_LED      = 30'd0;
  localparam logic [29:0] REG_CYCLE    = 30'd1;
  localparam logic [29:0] REG_STATUS   = 30'd2;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  state_t      state, nextState;
  logic        acc, mmio;
  logic        launch, ackHit, timeoutHit, localWr;
  logic [29:0] regWord;
  logic [7:0]  toCnt;
  logic [31:0] rdataQ, cycleCnt, localRdata;

  assign acc     = cpu_re | cpu_we;
  assign mmio    = (cpu_addr >= MMIO_BASE);
  // Word index into the register window; the byte offset is dropped.
  assign regWord = cpu_addr[31:2] - BASE_WORD;

  // Local register read mux.
  always_comb begin
    localRdata = 32'd0;
    case (regWord)
      REG_LED:    localRdata = {24'd0, led};
      REG_CYCLE:  localRdata = cycleCnt;
      REG_STATUS: localRdata = {31'd0, bus_err};
      default:    localRdata = 32'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next state, stall, read-data steering and the one-cycle action strobes.
  always_comb begin
    nextState  = state;
    stall      = 1'b0;
    cpu_rdata  = 32'd0;
    launch     = 1'b0;
    ackHit     = 1'b0;
    timeoutHit = 1'b0;
    localWr    = 1'b0;
    case (state)
      IDLE: begin
        if (acc && !mmio) begin
          launch    = 1'b1;
          stall     = 1'b1;
          nextState = REQ;
        end else if (acc && mmio) begin
          localWr = cpu_we;
          if (cpu_re) cpu_rdata = localRdata;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_ack) begin
          ackHit    = 1'b1;
          nextState = DONE;
        end else if (toCnt == TO_LAST) begin
          timeoutHit = 1'b1;
          nextState  = DONE;
        end
      end
      DONE: begin
        // The request still on the inputs is the one just completed.
        cpu_rdata = rdataQ;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Bus request/address/data: latched at launch, held through REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
    end else if (launch) begin
      bus_req   <= 1'b1;
      bus_we    <= cpu_we;
      bus_addr  <= {cpu_addr[31:2], 2'b00};
      bus_wdata <= cpu_wdata;
    end else if (ackHit || timeoutHit) begin
      bus_req <= 1'b0;
    end
  end

  // Timeout counter: cleared at launch, counts unanswered REQ cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              toCnt <= 8'd0;
    else if (launch)         toCnt <= 8'd0;
    else if (state == REQ)   toCnt <= toCnt + 8'd1;
  end

  // Completion data presented in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rdataQ <= 32'd0;
    else if (ackHit)     rdataQ <= bus_we ? 32'd0 : bus_rdata;
    else if (timeoutHit) rdataQ <= TIMEOUT_DATA;
  end

  // Sticky timeout flag, write-1-to-clear through STATUS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus_err <= 1'b0;
    else if (timeoutHit)
      bus_err <= 1'b1;
    else if (localWr && regWord == REG_STATUS && cpu_wdata[0])
      bus_err <= 1'b0;
  end

  // LED register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           led <= 8'd0;
    else if (localWr && regWord == REG_LED) led <= cpu_wdata[7:0];
  end

  // Free-running cycle counter; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycleCnt <= 32'd0;
    else        cycleCnt <= cycleCnt + 32'd1;
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed vector table, hand sequences for CYCLE spacing and
// reset during a bus access, then random accesses checked against a
// transaction-level model of the bridge.
module tb_dmem_bridge;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int          TMO  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack;
  logic [7:0]  led;
  logic        bus_err;

  dmem_bridge #(.MMIO_BASE(BASE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .led(led), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          re;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack;     // bus_req cycle in which to ack; 0 = never
    logic [31:0] brdata;
    bit          stray;   // drive bus_ack while no request is up
  } acc_t;

  typedef struct {
    acc_t        a;
    int          eStall;
    int          eReq;
    logic [31:0] eRdata;
    logic [31:0] eBAddr;
    logic        eBWe;
    logic [31:0] eBWdata;
    logic [7:0]  eLed;
    logic        eErr;
    bit          cycRead;
  } vec_t;

  typedef struct {
    bit          done;
    int          stallCnt;
    int          reqCnt;
    logic [31:0] rdata;
    logic [31:0] bAddr;
    logic        bWe;
    logic [31:0] bWdata;
    bit          stable;
    time         tDone;
    logic [7:0]  ledAfter;
    logic        errAfter;
    logic        idleStall;
  } res_t;

  int   nChecks = 0;
  int   nErrors = 0;
  time  tRel;
  logic [7:0] mLed;
  logic       mErr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(bit re, bit we, logic [31:0] addr, logic [31:0] wdata,
                               int ack, logic [31:0] brdata, bit stray,
                               int eStall, int eReq, logic [31:0] eRdata,
                               logic [31:0] eBAddr, logic eBWe, logic [31:0] eBWdata,
                               logic [7:0] eLed, logic eErr);
    vec_t v;
    v.a       = '{re, we, addr, wdata, ack, brdata, stray};
    v.eStall  = eStall;  v.eReq   = eReq;   v.eRdata  = eRdata;
    v.eBAddr  = eBAddr;  v.eBWe   = eBWe;   v.eBWdata = eBWdata;
    v.eLed    = eLed;    v.eErr   = eErr;   v.cycRead = 1'b0;
    return v;
  endfunction

  // Transaction-level model: what one access should look like from outside.
  task automatic predict(input acc_t a, output vec_t v);
    bit   isMmio;
    bit   tout;
    int   n;
    logic [31:0] word;
    v = mkv(a.re, a.we, a.addr, a.wdata, a.ack, a.brdata, a.stray,
            0, 0, 32'd0, 32'd0, 1'b0, 32'd0, 8'd0, 1'b0);
    isMmio = (a.addr >= BASE);
    if (!(a.re || a.we)) begin
      // nothing happens
    end else if (isMmio) begin
      word = (a.addr - BASE) / 4;
      if (a.re) begin
        if (word == 0)      v.eRdata = {24'd0, mLed};
        else if (word == 1) v.cycRead = 1'b1;
        else if (word == 2) v.eRdata = {31'd0, mErr};
      end
      if (a.we) begin
        if (word == 0) mLed = a.wdata[7:0];
        if (word == 2 && a.wdata[0]) mErr = 1'b0;
      end
    end else begin
      tout      = (a.ack == 0 || a.ack > TMO);
      n         = tout ? TMO : a.ack;
      v.eReq    = n;
      v.eStall  = n + 1;
      v.eBAddr  = a.addr & 32'hFFFF_FFFC;
      v.eBWe    = a.we;
      v.eBWdata = a.wdata;
      v.eRdata  = tout ? 32'hDEAD_BEEF : (a.we ? 32'd0 : a.brdata);
      if (tout) mErr = 1'b1;
    end
    v.eLed = mLed;
    v.eErr = mErr;
  endtask

  // Present one access, play bus slave, observe until the commit cycle,
  // then drop the request for one idle cycle.
  task automatic runAccess(input acc_t a, output res_t r);
    r.done = 1'b0; r.stallCnt = 0; r.reqCnt = 0; r.rdata = '0;
    r.bAddr = '0; r.bWe = 1'b0; r.bWdata = '0; r.stable = 1'b1; r.tDone = 0;
    @(negedge clk);
    cpu_re = a.re; cpu_we = a.we; cpu_addr = a.addr; cpu_wdata = a.wdata;
    bus_ack = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (bus_req) begin
        r.reqCnt++;
        if (r.reqCnt == 1) begin
          r.bAddr = bus_addr; r.bWe = bus_we; r.bWdata = bus_wdata;
        end else if (bus_addr !== r.bAddr || bus_we !== r.bWe || bus_wdata !== r.bWdata) begin
          r.stable = 1'b0;
        end
        bus_ack   = (r.reqCnt == a.ack);
        bus_rdata = (r.reqCnt == a.ack) ? a.brdata : $urandom;
      end else begin
        bus_ack   = a.stray;
        bus_rdata = $urandom;
      end
      if (!stall) begin
        r.rdata = cpu_rdata;
        r.tDone = $time;
        r.done  = 1'b1;
        break;
      end
      r.stallCnt++;
      @(negedge clk);
    end
    @(negedge clk);
    cpu_re = 1'b0; cpu_we = 1'b0; bus_ack = 1'b0;
    #1;
    r.ledAfter  = led;
    r.errAfter  = bus_err;
    r.idleStall = stall;
  endtask

  task automatic checkRes(input string tag, input vec_t v, input res_t r);
    chk({tag, ".done"},  32'(r.done), 32'd1);
    chk({tag, ".stall"}, 32'(r.stallCnt), 32'(v.eStall));
    chk({tag, ".req"},   32'(r.reqCnt), 32'(v.eReq));
    chk({tag, ".rdata"}, r.rdata, v.eRdata);
    if (v.eReq > 0) begin
      chk({tag, ".baddr"},  r.bAddr, v.eBAddr);
      chk({tag, ".bwe"},    32'(r.bWe), 32'(v.eBWe));
      chk({tag, ".bwdata"}, r.bWdata, v.eBWdata);
      chk({tag, ".stable"}, 32'(r.stable), 32'd1);
    end
    chk({tag, ".led"},   32'(r.ledAfter), 32'(v.eLed));
    chk({tag, ".err"},   32'(r.errAfter), 32'(v.eErr));
    chk({tag, ".idle"},  32'(r.idleStall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[$];
    vec_t        v, dummy;
    acc_t        a;
    res_t        r, r2;
    int          op, word;
    logic [31:0] cyc1;

    rst_n = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    bus_rdata = '0; bus_ack = 1'b0;
    mLed = 8'd0; mErr = 1'b0;

    // Reset state
    #1;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.rdata", cpu_rdata, 32'd0);
    chk("rst.breq",  32'(bus_req), 32'd0);
    chk("rst.bwe",   32'(bus_we), 32'd0);
    chk("rst.baddr", bus_addr, 32'd0);
    chk("rst.bwd",   bus_wdata, 32'd0);
    chk("rst.led",   32'(led), 32'd0);
    chk("rst.err",   32'(bus_err), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; tRel = $time;

    //         re we addr          wdata         ack brdata        stray stl req rdata         baddr         bwe bwdata        led    err
    tbl.push_back(mkv(0, 1, 32'hFFFF_0000, 32'h0000_00A5, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0,        0, 32'h0,         8'hA5, 0));
    tbl.push_back(mkv(1, 0, 32'hFFFF_0000, 32'h0,         0, 32'h0,         0, 0, 0, 32'h0000_00A5, 32'h0,        0, 32'h0,         8'hA5, 0));
    tbl.push_back(mkv(1, 0, 32'h0000_0010, 32'h0,         3, 32'h1234_5678, 1, 4, 3, 32'h1234_5678, 32'h10,       0, 32'h0,         8'hA5, 0));
    tbl.push_back(mkv(1, 1, 32'h0000_0013, 32'hCAFE_F00D, 1, 32'h5555_5555, 0, 2, 1, 32'h0,         32'h10,       1, 32'hCAFE_F00D, 8'hA5, 0));
    tbl.push_back(mkv(1, 0, 32'h0000_0100, 32'h0,         0, 32'h0,         0, 5, 4, 32'hDEAD_BEEF, 32'h100,      0, 32'h0,         8'hA5, 1));
    tbl.push_back(mkv(1, 0, 32'hFFFF_0008, 32'h0,         0, 32'h0,         1, 0, 0, 32'h1,         32'h0,        0, 32'h0,         8'hA5, 1));
    tbl.push_back(mkv(0, 1, 32'hFFFF_0008, 32'hFFFF_FFFE, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0,        0, 32'h0,         8'hA5, 1));
    tbl.push_back(mkv(0, 1, 32'hFFFF_0008, 32'h0000_0001, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0,        0, 32'h0,         8'hA5, 0));
    tbl.push_back(mkv(1, 0, 32'hFFFF_0008, 32'h0,         0, 32'h0,         0, 0, 0, 32'h0,         32'h0,        0, 32'h0,         8'hA5, 0));
    tbl.push_back(mkv(1, 0, 32'h2000_0006, 32'h0000_7777, 4, 32'h0BAD_F00D, 0, 5, 4, 32'h0BAD_F00D, 32'h2000_0004, 0, 32'h0000_7777, 8'hA5, 0));
    tbl.push_back(mkv(0, 1, 32'hFFFF_0003, 32'h1234_5633, 0, 32'h0,         1, 0, 0, 32'h0,         32'h0,        0, 32'h0,         8'h33, 0));
    tbl.push_back(mkv(1, 0, 32'hFFFF_0001, 32'h0,         0, 32'h0,         1, 0, 0, 32'h0000_0033, 32'h0,        0, 32'h0,         8'h33, 0));
    tbl.push_back(mkv(1, 0, 32'hFFFF_0010, 32'h0,         0, 32'h0,         0, 0, 0, 32'h0,         32'h0,        0, 32'h0,         8'h33, 0));
    tbl.push_back(mkv(0, 1, 32'hFFFF_0004, 32'hFFFF_FFFF, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0,        0, 32'h0,         8'h33, 0));
    tbl.push_back(mkv(0, 0, 32'h0000_0020, 32'h0,         2, 32'h0,         1, 0, 0, 32'h0,         32'h0,        0, 32'h0,         8'h33, 0));

    foreach (tbl[i]) begin
      predict(tbl[i].a, dummy);
      runAccess(tbl[i].a, r);
      checkRes($sformatf("vec%0d", i), tbl[i], r);
    end

    // CYCLE read twice, three cycles apart
    a = '{1'b1, 1'b0, 32'hFFFF_0004, 32'h0, 0, 32'h0, 1'b0};
    runAccess(a, r);
    cyc1 = r.rdata;
    chk("cyc.first", cyc1, 32'((r.tDone - tRel) / 10));
    chk("cyc.stall1", 32'(r.stallCnt), 32'd0);
    @(negedge clk); #1;
    chk("cyc.gapStall", 32'(stall), 32'd0);
    runAccess(a, r2);
    chk("cyc.diff", r2.rdata - cyc1, 32'd3);
    chk("cyc.stall2", 32'(r2.stallCnt), 32'd0);

    // Random accesses against the model
    for (int i = 0; i < 60; i++) begin
      op        = $urandom_range(0, 3);
      a.re      = (op == 1 || op == 3);
      a.we      = (op == 2 || op == 3);
      a.wdata   = $urandom;
      a.brdata  = $urandom;
      a.stray   = 1'($urandom_range(0, 1));
      a.ack     = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) begin
        word   = $urandom_range(0, 4);
        a.addr = BASE + 32'(word * 4) + 32'($urandom_range(0, 3));
      end else begin
        a.addr = $urandom & 32'hFFFE_FFFF;
      end
      predict(a, v);
      runAccess(a, r);
      if (v.cycRead) v.eRdata = 32'((r.tDone - tRel) / 10);
      checkRes($sformatf("rnd%0d", i), v, r);
    end

    // Reset in the middle of a bus access
    a = '{1'b0, 1'b1, 32'hFFFF_0000, 32'h0000_005A, 0, 32'h0, 1'b0};
    predict(a, v);
    runAccess(a, r);
    checkRes("preRst", v, r);
    @(negedge clk);
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040; bus_ack = 1'b0;
    @(negedge clk); #1;
    chk("midRst.reqUp", 32'(bus_req), 32'd1);
    #2;
    rst_n = 1'b0; cpu_re = 1'b0;
    #1;
    chk("midRst.breq",  32'(bus_req), 32'd0);
    chk("midRst.stall", 32'(stall), 32'd0);
    chk("midRst.rdata", cpu_rdata, 32'd0);
    chk("midRst.led",   32'(led), 32'd0);
    chk("midRst.baddr", bus_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; tRel = $time;
    mLed = 8'd0; mErr = 1'b0;

    a = '{1'b1, 1'b0, 32'hFFFF_0004, 32'h0, 0, 32'h0, 1'b0};
    predict(a, v);
    runAccess(a, r);
    v.eRdata = 32'((r.tDone - tRel) / 10);
    checkRes("postRst.cyc", v, r);
    a = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 2, 32'h0F0F_1234, 1'b0};
    predict(a, v);
    runAccess(a, r);
    checkRes("postRst.load", v, r);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
